// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RS->ALU execute stage; 2-cycle dispatch-to-result latency, S1/S2 pipe plus BUF_DEPTH result FIFO; alu_full stalls RS dispatch.
// Optional macro ALU_MUL_EN enables codes 21-24 (MUL/MULH/MULHSU/MULHU); without it those codes are NOPs.
module alu_exec_unit #(
    parameter int ROB_ID_BIT = 5,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_flag,
    input  logic [6:0]            alu_op,
    input  logic [31:0]           Vi,
    input  logic [31:0]           Vj,
    input  logic [31:0]           imm,
    input  logic [ROB_ID_BIT-1:0] rd,
    input  logic [31:0]           pc,
    input  logic                  cdb_grant,
    output logic                  alu_full,
    output logic                  alu_ready,
    output logic [ROB_ID_BIT-1:0] alu_ROB_id,
    output logic [31:0]           alu_val,
    output logic                  alu_jump,
    output logic [31:0]           alu_target
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ROB_ID_BIT-1:0] rob;
        logic [31:0]           val;
        logic                  jump;
        logic [31:0]           target;
    } res_t;

    logic                  s1_vld_q;
    logic [5:0]            s1_op_q;
    logic [31:0]           s1_a_q, s1_b_q, s1_imm_q, s1_pc_q;
    logic [ROB_ID_BIT-1:0] s1_rob_q;
    logic                  s2_vld_q;
    res_t                  s2_q;
    res_t                  buf_q [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q;

    res_t        res_d, pres;
    logic        buf_empty, push, pop, pop_buf;
    logic [CW+1:0] occ_sum;

    function automatic logic op_valid(input logic [5:0] c);
`ifdef ALU_MUL_EN
        return (c >= 6'd1) && (c <= 6'd24);
`else
        return (c >= 6'd1) && (c <= 6'd20);
`endif
    endfunction

`ifdef ALU_MUL_EN
    logic [63:0] p_ss, p_su, p_uu;
    assign p_ss = {{32{s1_a_q[31]}}, s1_a_q} * {{32{s1_b_q[31]}}, s1_b_q};
    assign p_su = {{32{s1_a_q[31]}}, s1_a_q} * {32'd0, s1_b_q};
    assign p_uu = {32'd0, s1_a_q} * {32'd0, s1_b_q};
`endif

    always_comb begin
        res_d        = '0;
        res_d.rob    = s1_rob_q;
        res_d.target = s1_pc_q + s1_imm_q;
        unique case (s1_op_q)
            6'd1:  res_d.val  = s1_a_q + s1_b_q;
            6'd2:  res_d.val  = s1_a_q - s1_b_q;
            6'd3:  res_d.val  = s1_a_q & s1_b_q;
            6'd4:  res_d.val  = s1_a_q | s1_b_q;
            6'd5:  res_d.val  = s1_a_q ^ s1_b_q;
            6'd6:  res_d.val  = s1_a_q << s1_b_q[4:0];
            6'd7:  res_d.val  = s1_a_q >> s1_b_q[4:0];
            6'd8:  res_d.val  = 32'($signed(s1_a_q) >>> s1_b_q[4:0]);
            6'd9:  res_d.val  = {31'd0, $signed(s1_a_q) < $signed(s1_b_q)};
            6'd10: res_d.val  = {31'd0, s1_a_q < s1_b_q};
            6'd11: res_d.jump = (s1_a_q == s1_b_q);
            6'd12: res_d.jump = (s1_a_q != s1_b_q);
            6'd13: res_d.jump = ($signed(s1_a_q) < $signed(s1_b_q));
            6'd14: res_d.jump = ($signed(s1_a_q) >= $signed(s1_b_q));
            6'd15: res_d.jump = (s1_a_q < s1_b_q);
            6'd16: res_d.jump = (s1_a_q >= s1_b_q);
            6'd17: begin
                res_d.val  = s1_pc_q + 32'd4;
                res_d.jump = 1'b1;
            end
            6'd18: begin
                res_d.val    = s1_pc_q + 32'd4;
                res_d.jump   = 1'b1;
                res_d.target = (s1_a_q + s1_imm_q) & ~32'd1;
            end
            6'd19: res_d.val = s1_imm_q;
            6'd20: res_d.val = s1_pc_q + s1_imm_q;
`ifdef ALU_MUL_EN
            6'd21: res_d.val = p_ss[31:0];
            6'd22: res_d.val = p_ss[63:32];
            6'd23: res_d.val = p_su[63:32];
            6'd24: res_d.val = p_uu[63:32];
`endif
            default: res_d.val = '0;
        endcase
    end

    // The buffer head always takes precedence so results leave in dispatch order.
    assign buf_empty = (cnt_q == '0);
    assign pres      = buf_empty ? s2_q : buf_q[rd_ptr_q];
    assign alu_ready = !buf_empty || s2_vld_q;
    assign pop       = alu_ready && cdb_grant;
    assign pop_buf   = pop && !buf_empty;
    assign push      = s2_vld_q && !(buf_empty && cdb_grant);

    assign occ_sum  = (CW+2)'(cnt_q) + (CW+2)'(s1_vld_q) + (CW+2)'(s2_vld_q);
    assign alu_full = (occ_sum >= (CW+2)'(BUF_DEPTH));

    assign alu_ROB_id = alu_ready ? pres.rob    : '0;
    assign alu_val    = alu_ready ? pres.val    : '0;
    assign alu_jump   = alu_ready ? pres.jump   : 1'b0;
    assign alu_target = alu_ready ? pres.target : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_flag) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (rdy_in) begin
            s1_vld_q <= op_valid(alu_op[5:0]) && !alu_full;
            if ((alu_op != 7'd0) && !alu_full) begin
                s1_op_q  <= alu_op[5:0];
                s1_a_q   <= Vi;
                s1_b_q   <= alu_op[6] ? imm : Vj;
                s1_imm_q <= imm;
                s1_pc_q  <= pc;
                s1_rob_q <= rd;
            end
            s2_vld_q <= s1_vld_q;
            s2_q     <= res_d;
            if (push) begin
                buf_q[wr_ptr_q] <= s2_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_buf) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop_buf})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule
